// File: rtl/imm_ext_pipe_pkg.sv
// Shared encodings for the immediate-extension mode, used by decode/control
// and by the extension datapath.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN   = 2'b00;
  localparam ext_mode_t EXT_ZERO   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bus between decode (master) and the immediate-extension queue (slave).
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) ();
  import imm_ext_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [IN_W-1:0]          in_imm;
  ext_mode_t                in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, level
  );

endinterface

// File: rtl/imm_ext_pipe_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) or branch offset.
// Also used directly by the single-cycle datapath.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHAMT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] sign_ext;

  // Width casts avoid zero-count replications when OUT_W == IN_W.
  always_comb begin
    sign_ext = OUT_W'($signed(imm));
    case (mode)
      EXT_SIGN:   result = sign_ext;
      EXT_ZERO:   result = OUT_W'(imm);
      EXT_UPPER:  result = OUT_W'(imm) << (OUT_W - IN_W);
      EXT_BRANCH: result = sign_ext << BR_SHAMT;
      default:    result = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: extends at push time and queues results
// in a DEPTH-entry FIFO so decode can run ahead of a stalled execute stage.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHAMT = 2,
  parameter int DEPTH    = 4
) (
  input logic         clk,
  input logic         reset,
  imm_ext_pipe_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_ext_pipe: IN_W must be >= 2");
  end
  if (OUT_W < IN_W + BR_SHAMT) begin : g_bad_out_w
    $error("imm_ext_pipe: OUT_W must be >= IN_W + BR_SHAMT");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_ext_pipe: DEPTH must be a power of two >= 2");
  end

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  level_w;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] ext_result;
  logic [OUT_W-1:0] last_popped;
  logic             push;
  logic             pop;
  logic             full;

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHAMT (BR_SHAMT)
  ) u_core (
    .imm    (bus.in_imm),
    .mode   (bus.in_mode),
    .result (ext_result)
  );

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign level_w = wr_ptr - rd_ptr;
  assign full    = (level_w == (ADDR_W+1)'(DEPTH));
  assign push    = bus.in_valid && !full;
  assign pop     = (level_w != '0) && bus.out_ready;

  assign bus.level     = level_w;
  assign bus.in_ready  = !full;
  assign bus.out_valid = (level_w != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr[ADDR_W-1:0]] : last_popped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_popped <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + (ADDR_W+1)'(1);
        last_popped <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // Storage needs no reset: an entry is only visible once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= ext_result;
    end
  end

endmodule
